multicycle_ctrl: RTL and testbench

//  Moore/Mealy FSM that sequences the multicycle RV datapath through FETCH, DECODE, EXEC, MEM and WB.

---
 rtl/multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control sequencer for a multicycle RV32 datapath: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Registered state, wait counter and sticky fault; every strobe is decoded from state, IR and ready/zero.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        fault
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] PC_SRC_BR   = 2'b01;

    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             r_fault;
    logic             w_fault_set;

    logic [6:0] w_opcode;
    logic       w_rd_nonzero;
    logic       w_is_r;
    logic       w_is_alui;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_branch;
    logic       w_is_lui;
    logic       w_is_auipc;
    logic       w_legal;
    logic       w_unused_instr_bits;

    logic       w_waiting_state;
    logic       w_wait_ready;
    logic       w_timeout;

    logic       w_imem_req;
    logic       w_dmem_req;
    logic       w_dmem_we;
    logic       w_ir_write;
    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic [1:0] w_alu_src_a;
    logic       w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic [1:0] w_wb_sel;

    assign w_opcode     = instr[6:0];
    assign w_rd_nonzero = |instr[11:7];
    assign w_is_r       = (w_opcode == OP_RTYPE);
    assign w_is_alui    = (w_opcode == OP_ALUI);
    assign w_is_load    = (w_opcode == OP_LOAD);
    assign w_is_store   = (w_opcode == OP_STORE);
    assign w_is_branch  = (w_opcode == OP_BRANCH);
    assign w_is_lui     = (w_opcode == OP_LUI);
    assign w_is_auipc   = (w_opcode == OP_AUIPC);
    assign w_legal      = w_is_r | w_is_alui | w_is_load | w_is_store |
                          w_is_branch | w_is_lui | w_is_auipc;
    assign w_unused_instr_bits = ^instr[31:12];

    // FETCH waits on imem, MEM on dmem; a ready in the last allowed cycle still wins.
    assign w_waiting_state = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_wait_ready    = (r_state == S_FETCH) ? imem_ready : dmem_ready;
    assign w_timeout       = w_waiting_state && !w_wait_ready &&
                             (r_wait_cnt == CNT_W'(MEM_TIMEOUT));

    always_comb begin
        w_next_state = r_state;
        w_fault_set  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                    w_fault_set  = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next_state = S_EXEC;
                end else begin
                    w_next_state = S_HALT;
                    w_fault_set  = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_is_load || w_is_store) begin
                    w_next_state = S_MEM;
                end else if (w_is_branch) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    w_next_state = w_is_store ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                    w_fault_set  = 1'b1;
                end
            end
            S_WB:   w_next_state = S_FETCH;
            S_HALT: w_next_state = S_HALT;
            default: begin
                w_next_state = S_HALT;
                w_fault_set  = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if ((w_next_state == S_FETCH || w_next_state == S_MEM) && (w_next_state != r_state)) begin
            w_wait_cnt_nxt = '0;
        end else if (w_waiting_state && !w_wait_ready && !w_timeout) begin
            w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'b00;
        w_alu_src_a = 2'b00;
        w_alu_src_b = 1'b0;
        w_alu_op    = ALU_ADD;
        w_reg_write = 1'b0;
        w_wb_sel    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_imem_req = !w_timeout;
                w_ir_write = imem_ready;
                w_pc_write = imem_ready;
            end
            S_EXEC: begin
                if (w_is_r) begin
                    w_alu_op = ALU_FUNCT;
                end else if (w_is_alui) begin
                    w_alu_src_b = 1'b1;
                    w_alu_op    = ALU_FUNCT;
                end else if (w_is_load || w_is_store) begin
                    w_alu_src_b = 1'b1;
                end else if (w_is_auipc) begin
                    w_alu_src_a = SRC_A_OLDPC;
                    w_alu_src_b = 1'b1;
                end else if (w_is_branch) begin
                    // Taken branch redirects the PC in the same cycle the ALU compares.
                    w_alu_op = ALU_SUB;
                    if (zero) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = PC_SRC_BR;
                    end
                end
            end
            S_MEM: begin
                w_dmem_req = !w_timeout;
                w_dmem_we  = !w_timeout && w_is_store;
            end
            S_WB: begin
                w_reg_write = w_rd_nonzero;
                if (w_is_load) begin
                    w_wb_sel = WB_MEM;
                end else if (w_is_lui) begin
                    w_wb_sel = WB_IMM;
                end
            end
            default: ;
        endcase
    end

    // Outputs are forced low the moment rst_n falls, not at the next edge.
    assign imem_req  = rst_n & w_imem_req;
    assign dmem_req  = rst_n & w_dmem_req;
    assign dmem_we   = rst_n & w_dmem_we;
    assign ir_write  = rst_n & w_ir_write;
    assign pc_write  = rst_n & w_pc_write;
    assign pc_src    = {2{rst_n}} & w_pc_src;
    assign alu_src_a = {2{rst_n}} & w_alu_src_a;
    assign alu_src_b = rst_n & w_alu_src_b;
    assign alu_op    = {2{rst_n}} & w_alu_op;
    assign reg_write = rst_n & w_reg_write;
    assign wb_sel    = {2{rst_n}} & w_wb_sel;
    assign state     = r_state;
    assign fault     = r_fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a route-based model of the instruction flow.
module tb_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 15;

    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_EXEC   = 2;
    localparam int P_MEM    = 3;
    localparam int P_WB     = 4;
    localparam int P_HALT   = 5;

    localparam int C_ILL   = -1;
    localparam int C_R     = 0;
    localparam int C_ALUI  = 1;
    localparam int C_LW    = 2;
    localparam int C_SW    = 3;
    localparam int C_BEQ   = 4;
    localparam int C_LUI   = 5;
    localparam int C_AUIPC = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        fault;

    multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: remaining phases of the current instruction; empty route means fetching.
    int          m_route[$];
    int          m_wait = 0;
    bit          m_halt = 1'b0;
    bit          m_fault = 1'b0;
    bit          m_loaded = 1'b0;
    logic [31:0] m_ir = 32'h0;
    logic [31:0] pend_instr = 32'h0;

    logic [2:0]  cap_state;
    logic        cap_imem_req, cap_dmem_req, cap_dmem_we, cap_ir_write, cap_pc_write;
    logic [1:0]  cap_pc_src, cap_alu_op, cap_wb_sel;
    logic        cap_alu_src_b, cap_reg_write, cap_fault;
    logic        pre_dmem_req;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cls(input logic [31:0] ir);
        case (ir[6:0])
            7'b0110011: return C_R;
            7'b0010011: return C_ALUI;
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b1100011: return C_BEQ;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int cur_phase();
        if (m_halt) return P_HALT;
        if (m_route.size() == 0) return P_FETCH;
        return m_route[0];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 15))
            0, 1:   r[6:0] = 7'b0110011;
            2, 3:   r[6:0] = 7'b0010011;
            4, 5:   r[6:0] = 7'b0000011;
            6, 7:   r[6:0] = 7'b0100011;
            8, 9:   r[6:0] = 7'b1100011;
            10, 11: r[6:0] = 7'b0110111;
            12, 13: r[6:0] = 7'b0010111;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    task automatic load_route(input int c);
        m_route.delete();
        m_route.push_back(P_DECODE);
        if (c != C_ILL) begin
            m_route.push_back(P_EXEC);
            if (c == C_LW || c == C_SW) m_route.push_back(P_MEM);
            if (c != C_SW && c != C_BEQ) m_route.push_back(P_WB);
        end
    endtask

    task automatic advance();
        void'(m_route.pop_front());
        m_wait = 0;
    endtask

    task automatic wait_or_fault();
        if (m_wait == MEM_TIMEOUT) begin
            m_halt = 1'b1;
            m_fault = 1'b1;
        end else begin
            m_wait++;
        end
    endtask

    task automatic model_step();
        int cur;
        m_loaded = 1'b0;
        cur = cur_phase();
        case (cur)
            P_HALT: ;
            P_FETCH: begin
                if (imem_ready) begin
                    m_ir = pend_instr;
                    m_loaded = 1'b1;
                    load_route(cls(pend_instr));
                    m_wait = 0;
                end else begin
                    wait_or_fault();
                end
            end
            P_DECODE: begin
                if (cls(m_ir) == C_ILL) begin
                    m_halt = 1'b1;
                    m_fault = 1'b1;
                end else begin
                    advance();
                end
            end
            P_MEM: begin
                if (dmem_ready) advance();
                else wait_or_fault();
            end
            default: advance();
        endcase
    endtask

    task automatic model_reset();
        m_route.delete();
        m_wait = 0;
        m_halt = 1'b0;
        m_fault = 1'b0;
    endtask

    // One clock: drive inputs, compare every output against the model, then advance the model.
    task automatic tick(input logic ir_rdy, input logic dm_rdy, input logic z);
        int cur, c;
        bit tmo;
        logic e_imem_req, e_dmem_req, e_dmem_we, e_ir_write, e_pc_write, e_alu_src_b, e_reg_write;
        logic [1:0] e_pc_src, e_alu_src_a, e_alu_op, e_wb_sel;
        @(negedge clk);
        imem_ready = ir_rdy;
        dmem_ready = dm_rdy;
        zero = z;
        #1;
        cur = cur_phase();
        c = cls(m_ir);
        e_imem_req = 0; e_dmem_req = 0; e_dmem_we = 0; e_ir_write = 0; e_pc_write = 0;
        e_alu_src_b = 0; e_reg_write = 0; e_pc_src = 0; e_alu_src_a = 0; e_alu_op = 0; e_wb_sel = 0;
        case (cur)
            P_FETCH: begin
                tmo = !imem_ready && (m_wait == MEM_TIMEOUT);
                e_imem_req = !tmo;
                e_ir_write = imem_ready;
                e_pc_write = imem_ready;
            end
            P_EXEC: begin
                case (c)
                    C_R:     e_alu_op = 2'b10;
                    C_ALUI:  begin e_alu_src_b = 1; e_alu_op = 2'b10; end
                    C_LW, C_SW: e_alu_src_b = 1;
                    C_AUIPC: begin e_alu_src_a = 2'b01; e_alu_src_b = 1; end
                    C_BEQ:   begin e_alu_op = 2'b01; e_pc_write = zero; e_pc_src = zero ? 2'b01 : 2'b00; end
                    default: ;
                endcase
            end
            P_MEM: begin
                tmo = !dmem_ready && (m_wait == MEM_TIMEOUT);
                e_dmem_req = !tmo;
                e_dmem_we = !tmo && (c == C_SW);
            end
            P_WB: begin
                e_reg_write = (m_ir[11:7] != 5'd0);
                e_wb_sel = (c == C_LW) ? 2'b01 : (c == C_LUI) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
        chk("state", state, cur);
        chk("fault", fault, m_fault);
        chk("imem_req", imem_req, e_imem_req);
        chk("dmem_req", dmem_req, e_dmem_req);
        chk("dmem_we", dmem_we, e_dmem_we);
        chk("ir_write", ir_write, e_ir_write);
        chk("pc_write", pc_write, e_pc_write);
        chk("pc_src", pc_src, e_pc_src);
        chk("alu_src_a", alu_src_a, e_alu_src_a);
        chk("alu_src_b", alu_src_b, e_alu_src_b);
        chk("alu_op", alu_op, e_alu_op);
        chk("reg_write", reg_write, e_reg_write);
        chk("wb_sel", wb_sel, e_wb_sel);
        cap_state = state; cap_imem_req = imem_req; cap_dmem_req = dmem_req; cap_dmem_we = dmem_we;
        cap_ir_write = ir_write; cap_pc_write = pc_write; cap_pc_src = pc_src; cap_alu_op = alu_op;
        cap_wb_sel = wb_sel; cap_alu_src_b = alu_src_b; cap_reg_write = reg_write; cap_fault = fault;
        @(posedge clk);
        model_step();
        #1;
        if (m_loaded) begin
            instr = m_ir;
            pend_instr = rand_instr();
        end
    endtask

    // Asynchronous reset asserted mid-cycle; released just after an edge so no edge is unmodelled.
    task automatic do_reset();
        @(negedge clk);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #2;
        pre_dmem_req = dmem_req;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_fault", fault, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_strobes", {dmem_we, ir_write, pc_write, reg_write, alu_src_b}, 0);
        chk("rst_selects", {pc_src, alu_src_a, alu_op, wb_sel}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        int cnt, ip, dp, halt_cnt;
        do_reset();

        // addi x1,x0,5
        pend_instr = 32'h00500093;
        tick(1, 0, 0); chk("addi_s0", cap_state, 0); chk("addi_irw", cap_ir_write, 1);
        tick(1, 0, 0); chk("addi_s1", cap_state, 1);
        tick(1, 0, 0); chk("addi_s2", cap_state, 2); chk("addi_b", cap_alu_src_b, 1); chk("addi_op", cap_alu_op, 2);
        tick(1, 0, 0); chk("addi_s4", cap_state, 4); chk("addi_rw", cap_reg_write, 1);

        // lw x2,8(x1) with dmem_ready on the fourth MEM cycle
        pend_instr = 32'h0080A103;
        tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(0, (i == 3), 0);
            if (cap_dmem_req && cap_state == 3'd3) cnt++;
            chk("lw_we", cap_dmem_we, 0);
        end
        chk("lw_req_cycles", cnt, 4);
        tick(0, 0, 0); chk("lw_wb_state", cap_state, 4); chk("lw_wbsel", cap_wb_sel, 1);

        // sw x2,4(x1)
        pend_instr = 32'h0020A223;
        cnt = 0;
        tick(1, 0, 0); cnt += cap_reg_write;
        tick(0, 0, 0); cnt += cap_reg_write;
        tick(0, 0, 0); cnt += cap_reg_write;
        tick(0, 1, 0); cnt += cap_reg_write;
        chk("sw_req", cap_dmem_req, 1); chk("sw_we", cap_dmem_we, 1);
        tick(0, 0, 0); cnt += cap_reg_write; chk("sw_back_fetch", cap_state, 0);
        chk("sw_no_regwrite", cnt, 0);

        // beq taken then not taken
        pend_instr = 32'h00000463;
        tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 1);
        chk("beq_t_pcw", cap_pc_write, 1); chk("beq_t_src", cap_pc_src, 1); chk("beq_t_op", cap_alu_op, 1);
        pend_instr = 32'h00000463;
        tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        chk("beq_nt_pcw", cap_pc_write, 0); chk("beq_nt_src", cap_pc_src, 0);

        // addi x0,x0,1 never writes the register file
        pend_instr = 32'h00100013;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin tick(i == 0, 0, 0); cnt += cap_reg_write; end
        chk("x0_state_wb", cap_state, 4); chk("x0_no_regwrite", cnt, 0);

        // imem timeout on the sixteenth wait cycle
        cnt = 0;
        for (int i = 0; i < 15; i++) begin tick(0, 0, 0); cnt += cap_imem_req; end
        chk("tmo_req_held", cnt, 15);
        tick(0, 0, 0); chk("tmo_req_drop", cap_imem_req, 0); chk("tmo_fault_not_yet", cap_fault, 0);
        tick(0, 0, 0); chk("tmo_halt", cap_state, 5); chk("tmo_fault", cap_fault, 1);
        do_reset();

        // ready arriving on the sixteenth wait cycle is accepted
        pend_instr = 32'h00500093;
        for (int i = 0; i < 15; i++) tick(0, 0, 0);
        tick(1, 0, 0); chk("late_rdy_irw", cap_ir_write, 1); chk("late_rdy_req", cap_imem_req, 1);
        tick(0, 0, 0); chk("late_rdy_decode", cap_state, 1); chk("late_rdy_nofault", cap_fault, 0);
        tick(0, 0, 0); tick(0, 0, 0);

        // dmem timeout
        pend_instr = 32'h0080A103;
        tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        for (int i = 0; i < 15; i++) tick(0, 0, 0);
        tick(0, 0, 0); chk("dtmo_req_drop", cap_dmem_req, 0);
        tick(0, 0, 0); chk("dtmo_halt", cap_state, 5); chk("dtmo_fault", cap_fault, 1);
        do_reset();

        // illegal opcode halts until reset
        pend_instr = 32'h0000007F;
        tick(1, 0, 0); tick(1, 0, 0); chk("ill_decode", cap_state, 1); chk("ill_nofault_yet", cap_fault, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 1, 1);
            if (cap_state == 3'd5 && cap_fault) cnt++;
        end
        chk("ill_halt_held", cnt, 20);
        do_reset();

        // reset while a load waits in MEM, then a clean fetch
        pend_instr = 32'h0080A103;
        tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        chk("midmem_state", cap_state, 3);
        do_reset();
        chk("midmem_req_before", pre_dmem_req, 1);
        pend_instr = 32'h00500093;
        tick(1, 0, 0); chk("post_rst_fetch", cap_ir_write, 1);
        tick(0, 0, 0); chk("post_rst_decode", cap_state, 1);
        tick(0, 0, 0); tick(0, 0, 0);

        // randomized traffic
        ip = 80; dp = 80; halt_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                ip = ($urandom_range(0, 2) == 0) ? 4 : 75;
                dp = ($urandom_range(0, 2) == 0) ? 4 : 75;
            end
            if (m_halt) begin
                halt_cnt++;
                if (halt_cnt > 4) begin do_reset(); halt_cnt = 0; end
            end else if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            tick($urandom_range(0, 99) < ip, $urandom_range(0, 99) < dp, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
